ahb_sram_slave: RTL and testbench

//  AHB-Lite slave fronting a word-organised on-chip SRAM; sits directly downstream of ahb_master
//  on the shared bus and serves both the core's instruction fetches and its data loads/stores.

---
 rtl/ahb_sram_slave.sv | 146 ++++++++++++++
 tb/tb_ahb_sram_slave.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/ahb_sram_slave.sv
// AHB-Lite slave in front of a word-organised SRAM: byte/half/word access,
// optional wait states and the two-cycle ERROR response.
module ahb_sram_slave #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          DEPTH_WORDS = 1024,
  parameter int          WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        hsel,
  input  logic [31:0] haddr,
  input  logic [1:0]  htrans,
  input  logic        hwrite,
  input  logic [2:0]  hsize,
  input  logic [31:0] hwdata,
  input  logic        hreadyin,
  output logic        hreadyout,
  output logic        hresp,
  output logic [31:0] hrdata
);

  localparam int          AW         = $clog2(DEPTH_WORDS);
  localparam logic [31:0] SPAN_BYTES = 32'(DEPTH_WORDS * 4);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ERR1, S_ERR2} state_e;

  state_e          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            dp_valid_q, dp_valid_d;
  logic            dp_write_q, dp_write_d;
  logic [1:0]      dp_size_q, dp_size_d;
  logic [AW+1:0]   dp_offset_q, dp_offset_d;

  logic [31:0]     mem_q [DEPTH_WORDS];
  logic [31:0]     offset;
  logic            accept;
  logic            addr_err;
  logic            phase_done;
  logic [AW-1:0]   word_idx;
  logic [3:0]      byte_en;
  logic            mem_we;
  logic [31:0]     mem_wdata;
  logic            unused_ok;

  assign unused_ok = htrans[0];
  assign offset    = haddr - BASE_ADDR;
  assign accept    = hsel & htrans[1] & hreadyin;
  // Addresses below BASE_ADDR wrap to a huge offset and fall out of range too.
  assign addr_err  = (offset >= SPAN_BYTES) | (hsize > 3'd2)
                   | ((hsize == 3'd1) & haddr[0])
                   | ((hsize == 3'd2) & (haddr[1:0] != 2'b00));
  assign word_idx  = dp_offset_q[AW+1:2];

  // NOTE: every variable gets a default at the top of the block so no path
  // leaves one unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    dp_valid_d  = dp_valid_q;
    dp_write_d  = dp_write_q;
    dp_size_d   = dp_size_q;
    dp_offset_d = dp_offset_q;
    phase_done  = 1'b1;
    hresp       = 1'b0;

    case (state_q)
      S_WAIT: begin
        phase_done = 1'b0;
        cnt_d      = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = S_IDLE;
      end
      S_ERR1: begin
        phase_done = 1'b0;
        hresp      = 1'b1;
        state_d    = S_ERR2;
      end
      S_ERR2: begin
        hresp   = 1'b1;
        state_d = S_IDLE;
      end
      default: ;
    endcase

    // The edge that ends a data phase may also open the next address phase.
    if (phase_done) begin
      dp_valid_d = 1'b0;
      if (accept) begin
        if (addr_err) begin
          state_d = S_ERR1;
        end else begin
          dp_valid_d  = 1'b1;
          dp_write_d  = hwrite;
          dp_size_d   = hsize[1:0];
          dp_offset_d = offset[AW+1:0];
          if (WAIT_STATES > 0) begin
            state_d = S_WAIT;
            cnt_d   = 4'(WAIT_STATES);
          end
        end
      end
    end
  end

  assign hreadyout = phase_done;

  always_comb begin
    case (dp_size_q)
      2'd0:    byte_en = 4'b0001 << dp_offset_q[1:0];
      2'd1:    byte_en = dp_offset_q[1] ? 4'b1100 : 4'b0011;
      default: byte_en = 4'b1111;
    endcase
    for (int n = 0; n < 4; n++) begin
      mem_wdata[8*n +: 8] = byte_en[n] ? hwdata[8*n +: 8] : mem_q[word_idx][8*n +: 8];
    end
  end

  assign mem_we = phase_done & dp_valid_q & dp_write_q;
  assign hrdata = (phase_done & dp_valid_q & ~dp_write_q & ~hresp) ? mem_q[word_idx] : 32'h0;

  // NOTE: state flops use non-blocking assignments so every flop samples the
  // pre-edge values of the others, independent of block ordering.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q     <= S_IDLE;
      cnt_q       <= 4'd0;
      dp_valid_q  <= 1'b0;
      dp_write_q  <= 1'b0;
      dp_size_q   <= 2'd0;
      dp_offset_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      dp_valid_q  <= dp_valid_d;
      dp_write_q  <= dp_write_d;
      dp_size_q   <= dp_size_d;
      dp_offset_q <= dp_offset_d;
    end
  end

  // NOTE: the array has no reset so it maps onto SRAM; a reset mid-transfer
  // clears dp_valid_q asynchronously, which is what suppresses the write.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[word_idx] <= mem_wdata;
  end

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Directed bench: a zero-wait and a two-wait-state slave share one AHB-Lite bus.
module tb_ahb_sram_slave;

  logic        clk = 1'b0;
  logic        nrst;
  logic        hsel0, hsel2;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [31:0] hwdata;
  logic        hreadyin;
  logic        hreadyout0, hreadyout2;
  logic        hresp0, hresp2;
  logic [31:0] hrdata0, hrdata2;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  assign hreadyin = hreadyout0 & hreadyout2;

  ahb_sram_slave #(.BASE_ADDR(32'h0), .DEPTH_WORDS(1024), .WAIT_STATES(0)) dut0 (
    .clk(clk), .nrst(nrst), .hsel(hsel0), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hsize(hsize), .hwdata(hwdata), .hreadyin(hreadyin),
    .hreadyout(hreadyout0), .hresp(hresp0), .hrdata(hrdata0)
  );

  ahb_sram_slave #(.BASE_ADDR(32'h0), .DEPTH_WORDS(1024), .WAIT_STATES(2)) dut2 (
    .clk(clk), .nrst(nrst), .hsel(hsel2), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hsize(hsize), .hwdata(hwdata), .hreadyin(hreadyin),
    .hreadyout(hreadyout2), .hresp(hresp2), .hrdata(hrdata2)
  );

  task automatic bus_idle();
    hsel0  = 1'b0;
    hsel2  = 1'b0;
    htrans = 2'b00;
    hwrite = 1'b0;
    hsize  = 3'd2;
    haddr  = 32'h0;
  endtask

  // Single non-pipelined transfer; waits counts data-phase cycles with HREADY low.
  task automatic xfer(input bit sel2, input logic [31:0] addr, input bit wr,
                      input logic [2:0] size, input logic [31:0] wdata,
                      output logic [31:0] rdata, output logic resp,
                      output int waits, output logic resp_first);
    @(negedge clk);
    hsel0  = !sel2;
    hsel2  = sel2;
    haddr  = addr;
    htrans = 2'b10;
    hwrite = wr;
    hsize  = size;
    @(negedge clk);
    bus_idle();
    hwdata     = wdata;
    waits      = 0;
    resp_first = sel2 ? hresp2 : hresp0;
    while (!hreadyin && waits < 20) begin
      waits++;
      @(negedge clk);
    end
    rdata = sel2 ? hrdata2 : hrdata0;
    resp  = sel2 ? hresp2 : hresp0;
  endtask

  task automatic test_reset();
    nrst   = 1'b0;
    hwdata = 32'h0;
    bus_idle();
    #12;
    total++; if (hreadyout0 !== 1'b1) $display("FAIL reset_ready0 got %b want 1", hreadyout0); else passed++;
    total++; if (hresp0 !== 1'b0) $display("FAIL reset_resp0 got %b want 0", hresp0); else passed++;
    total++; if (hrdata0 !== 32'h0) $display("FAIL reset_rdata0 got %h want 0", hrdata0); else passed++;
    total++; if (hreadyout2 !== 1'b1) $display("FAIL reset_ready2 got %b want 1", hreadyout2); else passed++;
    total++; if (hresp2 !== 1'b0) $display("FAIL reset_resp2 got %b want 0", hresp2); else passed++;
    total++; if (hrdata2 !== 32'h0) $display("FAIL reset_rdata2 got %h want 0", hrdata2); else passed++;
    @(negedge clk);
    nrst = 1'b1;
  endtask

  task automatic test_word_rw();
    logic [31:0] rd; logic rs, rf; int w;
    xfer(1'b0, 32'h10, 1'b1, 3'd2, 32'hDEADBEEF, rd, rs, w, rf);
    total++; if (w !== 0) $display("FAIL word_wr_waits got %0d want 0", w); else passed++;
    total++; if (rs !== 1'b0) $display("FAIL word_wr_resp got %b want 0", rs); else passed++;
    xfer(1'b0, 32'h10, 1'b0, 3'd2, 32'h0, rd, rs, w, rf);
    total++; if (w !== 0) $display("FAIL word_rd_waits got %0d want 0", w); else passed++;
    total++; if (rs !== 1'b0) $display("FAIL word_rd_resp got %b want 0", rs); else passed++;
    total++; if (rd !== 32'hDEADBEEF) $display("FAIL word_rd_data got %h want deadbeef", rd); else passed++;
  endtask

  task automatic test_byte_half();
    logic [31:0] rd; logic rs, rf; int w;
    xfer(1'b0, 32'h10, 1'b1, 3'd2, 32'h11223344, rd, rs, w, rf);
    xfer(1'b0, 32'h11, 1'b1, 3'd0, 32'h0000A500, rd, rs, w, rf);
    total++; if (rs !== 1'b0) $display("FAIL byte_wr_resp got %b want 0", rs); else passed++;
    xfer(1'b0, 32'h10, 1'b0, 3'd2, 32'h0, rd, rs, w, rf);
    total++; if (rd !== 32'h1122A544) $display("FAIL byte_merge got %h want 1122a544", rd); else passed++;
    xfer(1'b0, 32'h12, 1'b1, 3'd1, 32'hBEEF0000, rd, rs, w, rf);
    total++; if (rs !== 1'b0) $display("FAIL half_wr_resp got %b want 0", rs); else passed++;
    xfer(1'b0, 32'h10, 1'b0, 3'd2, 32'h0, rd, rs, w, rf);
    total++; if (rd !== 32'hBEEFA544) $display("FAIL half_merge got %h want beefa544", rd); else passed++;
  endtask

  task automatic test_wait_states();
    logic [31:0] rd; logic rs, rf; int w;
    xfer(1'b1, 32'h4, 1'b1, 3'd2, 32'h01234567, rd, rs, w, rf);
    total++; if (w !== 2) $display("FAIL ws_wr_waits got %0d want 2", w); else passed++;
    xfer(1'b1, 32'h4, 1'b0, 3'd2, 32'h0, rd, rs, w, rf);
    total++; if (w !== 2) $display("FAIL ws_rd_waits got %0d want 2", w); else passed++;
    total++; if (rs !== 1'b0) $display("FAIL ws_rd_resp got %b want 0", rs); else passed++;
    total++; if (rd !== 32'h01234567) $display("FAIL ws_rd_data got %h want 01234567", rd); else passed++;
  endtask

  task automatic test_error();
    logic [31:0] rd; logic rs, rf; int w;
    xfer(1'b0, 32'h0, 1'b1, 3'd2, 32'h0BADF00D, rd, rs, w, rf);
    xfer(1'b0, 32'h1000, 1'b0, 3'd2, 32'h0, rd, rs, w, rf);
    total++; if (w !== 1) $display("FAIL oob_waits got %0d want 1", w); else passed++;
    total++; if (rf !== 1'b1) $display("FAIL oob_resp_c1 got %b want 1", rf); else passed++;
    total++; if (rs !== 1'b1) $display("FAIL oob_resp_c2 got %b want 1", rs); else passed++;
    total++; if (rd !== 32'h0) $display("FAIL oob_rdata got %h want 0", rd); else passed++;
    xfer(1'b0, 32'h2, 1'b1, 3'd2, 32'hFFFFFFFF, rd, rs, w, rf);
    total++; if (w !== 1 || rf !== 1'b1 || rs !== 1'b1)
      $display("FAIL misalign_resp got waits=%0d r1=%b r2=%b want 1/1/1", w, rf, rs); else passed++;
    xfer(1'b0, 32'h0, 1'b1, 3'd3, 32'hFFFFFFFF, rd, rs, w, rf);
    total++; if (w !== 1 || rf !== 1'b1 || rs !== 1'b1)
      $display("FAIL badsize_resp got waits=%0d r1=%b r2=%b want 1/1/1", w, rf, rs); else passed++;
    xfer(1'b0, 32'h0, 1'b0, 3'd2, 32'h0, rd, rs, w, rf);
    total++; if (rd !== 32'h0BADF00D) $display("FAIL err_no_write got %h want 0badf00d", rd); else passed++;
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    hsel0 = 1'b1; haddr = 32'h8; htrans = 2'b10; hwrite = 1'b1; hsize = 3'd2;
    @(negedge clk);
    haddr = 32'h8; htrans = 2'b10; hwrite = 1'b0; hwdata = 32'hCAFEF00D;
    total++; if (hreadyout0 !== 1'b1) $display("FAIL b2b_wr_ready got %b want 1", hreadyout0); else passed++;
    @(negedge clk);
    bus_idle();
    total++; if (hreadyout0 !== 1'b1) $display("FAIL b2b_rd_ready got %b want 1", hreadyout0); else passed++;
    total++; if (hresp0 !== 1'b0) $display("FAIL b2b_rd_resp got %b want 0", hresp0); else passed++;
    total++; if (hrdata0 !== 32'hCAFEF00D) $display("FAIL b2b_rd_data got %h want cafef00d", hrdata0); else passed++;
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd; logic rs, rf; int w;
    xfer(1'b1, 32'hC, 1'b1, 3'd2, 32'h55AA55AA, rd, rs, w, rf);
    @(negedge clk);
    hsel2 = 1'b1; haddr = 32'hC; htrans = 2'b10; hwrite = 1'b1; hsize = 3'd2;
    @(negedge clk);
    bus_idle();
    hwdata = 32'h12345678;
    total++; if (hreadyout2 !== 1'b0) $display("FAIL mid_in_wait got %b want 0", hreadyout2); else passed++;
    #1 nrst = 1'b0;
    #1;
    total++; if (hreadyout2 !== 1'b1 || hresp2 !== 1'b0 || hrdata2 !== 32'h0)
      $display("FAIL mid_reset_outs got rdy=%b resp=%b data=%h want 1/0/0", hreadyout2, hresp2, hrdata2); else passed++;
    @(negedge clk);
    @(negedge clk);
    nrst = 1'b1;
    xfer(1'b1, 32'hC, 1'b0, 3'd2, 32'h0, rd, rs, w, rf);
    total++; if (rd !== 32'h55AA55AA) $display("FAIL mid_no_write got %h want 55aa55aa", rd); else passed++;
    xfer(1'b0, 32'h10, 1'b0, 3'd2, 32'h0, rd, rs, w, rf);
    total++; if (rd !== 32'hBEEFA544) $display("FAIL mem_kept got %h want beefa544", rd); else passed++;
  endtask

  initial begin
    test_reset();
    test_word_rw();
    test_byte_half();
    test_wait_states();
    test_error();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
